// File: rtl/red_pitaya_scope_pkg.sv
// Shared types and constants for the scope acquisition sequencer.
package red_pitaya_scope_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } acq_state_e;

  localparam int TRG_N = 10;

  localparam logic [3:0] TRG_NONE  = 4'd0;
  localparam logic [3:0] TRG_SW    = 4'd1;
  localparam logic [3:0] TRG_A_P   = 4'd2;
  localparam logic [3:0] TRG_A_N   = 4'd3;
  localparam logic [3:0] TRG_B_P   = 4'd4;
  localparam logic [3:0] TRG_B_N   = 4'd5;
  localparam logic [3:0] TRG_EXT_P = 4'd6;
  localparam logic [3:0] TRG_EXT_N = 4'd7;
  localparam logic [3:0] TRG_ASG_P = 4'd8;
  localparam logic [3:0] TRG_ASG_N = 4'd9;

  function automatic logic src_valid(input logic [3:0] src);
    return (src >= TRG_SW) && (src <= TRG_ASG_N);
  endfunction

endpackage

// File: rtl/red_pitaya_scope_wptr.sv
// Capture RAM write pointer: synchronous clear beats increment, wraps silently.
module red_pitaya_scope_wptr #(
  parameter int RSZ = 14
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [RSZ-1:0] ptr_o
);

  logic [RSZ-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)     ptr_d = '0;
    else if (en_i) ptr_d = ptr_q + RSZ'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/red_pitaya_scope_acq_ctrl.sv
// Scope acquisition sequencer: arm/trigger/post-delay FSM and RAM write generation.
module red_pitaya_scope_acq_ctrl
  import red_pitaya_scope_pkg::*;
#(
  parameter int RSZ = 14,
  parameter int DW  = 32
) (
  input  logic             adc_clk_i,
  input  logic             adc_rstn_i,
  input  logic             dec_val_i,
  input  logic             cfg_arm_i,
  input  logic             cfg_rst_i,
  input  logic [3:0]       cfg_src_i,
  input  logic [DW-1:0]    cfg_pre_i,
  input  logic [DW-1:0]    cfg_dly_i,
  input  logic [TRG_N-1:0] trg_vec_i,
  output logic             wen_o,
  output logic [RSZ-1:0]   waddr_o,
  output logic [RSZ-1:0]   trg_addr_o,
  output logic             trg_o,
  output logic [3:0]       trg_src_o,
  output logic             busy_o,
  output logic             done_o
);

  acq_state_e     state_d, state_q;
  logic [DW-1:0]  pre_d, pre_q;
  logic [DW-1:0]  post_d, post_q;
  logic [DW-1:0]  dly_d, dly_q;
  logic [RSZ-1:0] waddr_d, waddr_q;
  logic [RSZ-1:0] trg_addr_d, trg_addr_q;
  logic [3:0]     trg_src_d, trg_src_q;
  logic           wen_d, wen_q;
  logic           trg_d, trg_q;

  logic [RSZ-1:0] wptr;
  logic [15:0]    trg_ext;
  logic           writing, wr, arm_ok, accept;

  // Pad to 16 so every 4-bit source code indexes a defined bit.
  assign trg_ext = {{(16-TRG_N){1'b0}}, trg_vec_i};

  assign writing = (state_q == ARMED) || (state_q == TRIGGERED);
  assign wr      = dec_val_i && writing && !cfg_rst_i;
  assign arm_ok  = cfg_arm_i && !cfg_rst_i && ((state_q == IDLE) || (state_q == DONE));
  assign accept  = (state_q == ARMED) && !cfg_rst_i && src_valid(cfg_src_i)
                   && trg_ext[cfg_src_i] && (pre_q >= cfg_pre_i);

  red_pitaya_scope_wptr #(.RSZ(RSZ)) u_wptr (
    .clk_i  (adc_clk_i),
    .rstn_i (adc_rstn_i),
    .clr_i  (cfg_rst_i || arm_ok),
    .en_i   (wr),
    .ptr_o  (wptr)
  );

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    post_d     = post_q;
    dly_d      = dly_q;
    waddr_d    = waddr_q;
    trg_addr_d = trg_addr_q;
    trg_src_d  = trg_src_q;
    wen_d      = wr;
    trg_d      = accept;

    if (wr) waddr_d = wptr;

    unique case (state_q)
      IDLE, DONE: begin
        if (arm_ok) begin
          state_d    = ARMED;
          pre_d      = '0;
          post_d     = '0;
          trg_addr_d = '0;
          trg_src_d  = '0;
        end
      end
      ARMED: begin
        if (wr && (pre_q != '1)) pre_d = pre_q + DW'(1);
        if (accept) begin
          trg_src_d  = cfg_src_i;
          // With no write this cycle the trigger belongs to the last sample written.
          trg_addr_d = dec_val_i ? wptr : wptr - RSZ'(1);
          dly_d      = cfg_dly_i;
          post_d     = '0;
          state_d    = (cfg_dly_i == '0) ? DONE : TRIGGERED;
        end
      end
      TRIGGERED: begin
        if (wr) begin
          post_d = post_q + DW'(1);
          if (post_d == dly_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg_rst_i) begin
      state_d    = IDLE;
      pre_d      = '0;
      post_d     = '0;
      dly_d      = '0;
      waddr_d    = '0;
      trg_addr_d = '0;
      trg_src_d  = '0;
      wen_d      = 1'b0;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      post_q     <= '0;
      dly_q      <= '0;
      waddr_q    <= '0;
      trg_addr_q <= '0;
      trg_src_q  <= '0;
      wen_q      <= 1'b0;
      trg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      dly_q      <= dly_d;
      waddr_q    <= waddr_d;
      trg_addr_q <= trg_addr_d;
      trg_src_q  <= trg_src_d;
      wen_q      <= wen_d;
      trg_q      <= trg_d;
    end
  end

  assign wen_o      = wen_q;
  assign waddr_o    = waddr_q;
  assign trg_addr_o = trg_addr_q;
  assign trg_o      = trg_q;
  assign trg_src_o  = trg_src_q;
  assign busy_o     = (state_q == ARMED) || (state_q == TRIGGERED);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_red_pitaya_scope_acq_ctrl.sv
// Bench: two depths (RSZ=6 and RSZ=4) driven in parallel against a write-count model.
module tb_red_pitaya_scope_acq_ctrl;
  import red_pitaya_scope_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        dec_val = 1'b0, cfg_arm = 1'b0, cfg_rst = 1'b0;
  logic [3:0]  cfg_src = TRG_SW;
  logic [31:0] cfg_pre = '0, cfg_dly = 32'd20;
  logic [9:0]  trg_vec = '0;

  logic       wen6, trg6, busy6, done6;
  logic [5:0] waddr6, taddr6;
  logic [3:0] tsrc6;
  logic       wen4, trg4, busy4, done4;
  logic [3:0] waddr4, taddr4;
  logic [3:0] tsrc4;

  always #5 clk = ~clk;

  red_pitaya_scope_acq_ctrl #(.RSZ(6), .DW(32)) dut6 (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .dec_val_i(dec_val), .cfg_arm_i(cfg_arm),
    .cfg_rst_i(cfg_rst), .cfg_src_i(cfg_src), .cfg_pre_i(cfg_pre), .cfg_dly_i(cfg_dly),
    .trg_vec_i(trg_vec), .wen_o(wen6), .waddr_o(waddr6), .trg_addr_o(taddr6),
    .trg_o(trg6), .trg_src_o(tsrc6), .busy_o(busy6), .done_o(done6));

  red_pitaya_scope_acq_ctrl #(.RSZ(4), .DW(32)) dut4 (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .dec_val_i(dec_val), .cfg_arm_i(cfg_arm),
    .cfg_rst_i(cfg_rst), .cfg_src_i(cfg_src), .cfg_pre_i(cfg_pre), .cfg_dly_i(cfg_dly),
    .trg_vec_i(trg_vec), .wen_o(wen4), .waddr_o(waddr4), .trg_addr_o(taddr4),
    .trg_o(trg4), .trg_src_o(tsrc4), .busy_o(busy4), .done_o(done4));

  int n_vec = 0, n_fail = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for trigger, 2 post-trigger, 3 finished.
  // m_nw counts writes since arm; addresses are that count modulo the depth.
  int     m_phase = 0;
  longint m_nw = 0, m_left = 0;
  bit     e_wen = 0, e_trg = 0, e_tvalid = 0;
  longint e_waddr = 0, e_taddr = 0;
  int     e_src = 0;
  bit     m_wr, m_acc;
  int     m_prev;

  always @(posedge clk) begin
    if (!rstn) begin
      m_phase = 0; m_nw = 0; m_left = 0;
      e_wen = 0; e_trg = 0; e_tvalid = 0; e_waddr = 0; e_taddr = 0; e_src = 0;
    end else begin
      m_prev = m_phase;
      m_wr  = dec_val && (m_phase == 1 || m_phase == 2) && !cfg_rst;
      m_acc = (m_phase == 1) && !cfg_rst && cfg_src >= 1 && cfg_src <= 9
              && trg_vec[cfg_src] && (m_nw >= longint'(cfg_pre));
      e_wen = m_wr;
      e_trg = m_acc;
      if (cfg_rst) begin
        m_phase = 0; m_nw = 0; e_waddr = 0; e_tvalid = 0;
      end else begin
        if (m_wr) e_waddr = m_nw;
        if (m_acc) begin
          e_tvalid = 1;
          e_src    = int'(cfg_src);
          e_taddr  = dec_val ? m_nw : m_nw - 1;
          m_left   = longint'(cfg_dly);
          m_phase  = (cfg_dly == 0) ? 3 : 2;
        end else if (m_phase == 2 && m_wr) begin
          m_left--;
          if (m_left == 0) m_phase = 3;
        end
        if (m_wr) m_nw++;
        if (cfg_arm && (m_prev == 0 || m_prev == 3)) begin
          m_phase = 1; m_nw = 0; e_tvalid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("wen6", wen6, e_wen);
      chk("wen4", wen4, e_wen);
      chk("waddr6", waddr6, e_waddr & 63);
      chk("waddr4", waddr4, e_waddr & 15);
      chk("trg6", trg6, e_trg);
      chk("trg4", trg4, e_trg);
      chk("busy6", busy6, (m_phase == 1 || m_phase == 2));
      chk("done6", done6, (m_phase == 3));
      chk("done4", done4, (m_phase == 3));
      if (e_tvalid) begin
        chk("taddr6", taddr6, e_taddr & 63);
        chk("taddr4", taddr4, e_taddr & 15);
        chk("tsrc6", tsrc6, e_src);
        chk("tsrc4", tsrc4, e_src);
      end
    end
  end

  task automatic step(input bit dv, input bit arm = 0, input bit rst = 0,
                      input logic [9:0] trg = '0);
    dec_val = dv; cfg_arm = arm; cfg_rst = rst; trg_vec = trg;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int per, input int max_cyc, output int nwr);
    nwr = 0;
    for (int k = 0; k < max_cyc; k++) begin
      step((k % per) == per - 1);
      if (wen6) nwr++;
      if (done6) break;
    end
    chk("done_timeout", done6, 1);
  endtask

  function automatic logic [9:0] bit_of(input logic [3:0] src);
    logic [9:0] v;
    v = '0;
    v[src] = 1'b1;
    return v;
  endfunction

  int nw;

  initial begin
    #2 rstn = 1'b0;
    @(posedge clk); started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_waddr", waddr6, 0);
    chk("rst_busy", busy6, 0);
    rstn = 1'b1;
    step(0);

    // software trigger 20 cycles after arm
    cfg_pre = 0; cfg_dly = 20; cfg_src = TRG_SW;
    step(1, 1);
    repeat (19) step(1);
    step(1, 0, 0, bit_of(TRG_SW));
    chk("sw_taddr", taddr6, 19);
    wait_done(1, 100, nw);
    chk("sw_post_writes", nw, 20);
    chk("sw_last_addr", waddr6, 39);
    step(1);
    chk("sw_wen_off", wen6, 0);

    // pre-fill gating
    cfg_pre = 50; cfg_src = TRG_A_P;
    step(1, 1);
    for (int i = 0; i < 60; i++) step(1, 0, 0, (i == 10) ? bit_of(TRG_A_P) : 10'b0);
    step(1, 0, 0, bit_of(TRG_A_P));
    chk("pre_taddr", taddr6, 60);
    chk("pre_tsrc", tsrc6, 2);
    wait_done(1, 100, nw);

    // wrap on the 16-deep instance
    cfg_pre = 0; cfg_src = TRG_SW; cfg_dly = 20;
    step(1, 1);
    repeat (14) step(1);
    step(1, 0, 0, bit_of(TRG_SW));
    chk("wrap_taddr4", taddr4, 14);
    wait_done(1, 100, nw);
    chk("wrap_post_writes", nw, 20);
    chk("wrap_last_addr4", waddr4, 2);

    // decimated stall, trigger on a non-valid cycle
    cfg_dly = 3; cfg_src = TRG_B_P;
    step(0, 1);
    for (int k = 0; k < 40; k++) step((k % 8) == 7);
    step(0, 0, 0, bit_of(TRG_B_P));
    chk("stall_taddr", taddr6, 4);
    wait_done(8, 100, nw);
    chk("stall_post_writes", nw, 3);
    chk("stall_last_addr", waddr6, 7);

    // abort mid-TRIGGERED
    cfg_dly = 20; cfg_src = TRG_SW;
    step(1, 1);
    repeat (5) step(1);
    step(1, 0, 0, bit_of(TRG_SW));
    repeat (5) step(1);
    step(1, 0, 1);
    chk("abort_busy", busy6, 0);
    chk("abort_wen", wen6, 0);
    chk("abort_waddr", waddr6, 0);
    repeat (5) step(1);

    // zero delay, then reset+arm together from DONE
    cfg_dly = 0;
    step(1, 1);
    repeat (3) step(1);
    step(1, 0, 0, bit_of(TRG_SW));
    chk("dly0_done", done6, 1);
    chk("dly0_wen", wen6, 1);
    step(1);
    chk("dly0_wen_off", wen6, 0);
    step(1, 1, 1);
    chk("rstarm_done", done6, 0);
    chk("rstarm_busy", busy6, 0);

    // source 12 never fires; re-arm while ARMED keeps the pointer
    cfg_src = 4'd12; cfg_dly = 2;
    step(1, 1);
    repeat (20) step(1, 0, 0, 10'h3FF);
    chk("src12_busy", busy6, 1);
    step(1, 1);
    step(1);
    chk("rearm_waddr", waddr6, 21);

    // pre-fill boundary: 22 writes < 23 rejected, 23 >= 23 accepted
    cfg_pre = 23; cfg_src = TRG_EXT_P;
    step(1, 0, 0, bit_of(TRG_EXT_P));
    step(1, 0, 0, bit_of(TRG_EXT_P));
    chk("bound_taddr", taddr6, 23);
    cfg_dly = 100;
    wait_done(1, 50, nw);
    chk("dly_captured", nw, 2);
    step(0);

    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
